mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 4-bit mux (mux_8to1) between eight requesters.
- Picks one pending requester and drives the mux select.
- Registers the selected nibble and presents it on a valid/ready output handshake.
- Signals completion back to the winning requester with a one-cycle ack pulse.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/mux_8to1.sv | 33 +++
 rtl/mux_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] base;
    base   = {{(N_REQ-1){1'b0}}, 1'b1};
    onehot = base << s;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Plain 8:1 multiplexer of DATA_W-bit nibbles.
module mux_8to1
  import mux_arb_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [DATA_W-1:0] out
);

  // Route the selected input to the output.
  always_comb begin
    out = {DATA_W{1'b0}};
    case (sel)
      3'd0:    out = in0;
      3'd1:    out = in1;
      3'd2:    out = in2;
      3'd3:    out = in3;
      3'd4:    out = in4;
      3'd5:    out = in5;
      3'd6:    out = in6;
      3'd7:    out = in7;
      default: out = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 nibble mux between eight requesters,
// with a registered valid/ready output and a one-cycle ack to the winner.
module mux_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  ack,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_t              state_r, state_s;
  logic [SEL_W-1:0]    ptr_r, ptr_s;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic [N_REQ-1:0]    grant_r, grant_s;
  logic [N_REQ-1:0]    ack_r, ack_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                valid_r, valid_s;
  logic                busy_r, busy_s;

  logic [2*N_REQ-1:0]  req_dbl_s;
  logic [N_REQ-1:0]    req_rot_s;
  logic [SEL_W-1:0]    offset_s;
  logic [SEL_W-1:0]    winner_s;
  logic [DATA_W-1:0]   mux_out_s;

  // The mux always looks at the registered select, so it is settled one
  // cycle after the grant and its output is captured at the SELECT edge.
  mux_8to1 u_mux (
    .sel (sel_r),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .in6 (in6),
    .in7 (in7),
    .out (mux_out_s)
  );

  // Rotate req so ptr sits at bit 0, find the first set bit, un-rotate.
  always_comb begin
    req_dbl_s = {req, req};
    req_rot_s = req_dbl_s[ptr_r +: N_REQ];
    offset_s  = {SEL_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot_s[i]) begin
        offset_s = SEL_W'(i);
      end else begin
        offset_s = offset_s;
      end
    end
    winner_s = ptr_r + offset_s;
  end

  // Next-state and next-datapath decode for the IDLE/SELECT/HOLD sequence.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    grant_s = grant_r;
    ack_s   = {N_REQ{1'b0}};
    data_s  = data_r;
    valid_s = valid_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          sel_s   = winner_s;
          grant_s = onehot(winner_s);
          state_s = SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: begin
        data_s  = mux_out_s;
        valid_s = 1'b1;
        state_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_s = 1'b0;
          grant_s = {N_REQ{1'b0}};
          ack_s   = onehot(sel_r);
          ptr_s   = sel_r + 3'd1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        valid_s = 1'b0;
        grant_s = {N_REQ{1'b0}};
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset drops any in-flight transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r   <= 3'd0;
      sel_r   <= 3'd0;
      grant_r <= 8'd0;
      ack_r   <= 8'd0;
      data_r  <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign grant     = grant_r;
  assign ack       = ack_r;
  assign sel       = sel_r;
  assign data_out  = data_r;
  assign out_valid = valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, scoreboard queue and
// hand-written sequences for backpressure and reset during HOLD.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [3:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [7:0] grant, ack;
  logic [2:0] sel;
  logic [3:0] data_out;
  logic       out_valid, out_ready, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  req;
    logic [31:0] din;
    logic [2:0]  sel;
    logic [3:0]  dout;
  } vec_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] data;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  mux_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .grant(grant), .ack(ack), .sel(sel), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_din(input logic [31:0] d);
    in0 = d[3:0];   in1 = d[7:4];   in2 = d[11:8];  in3 = d[15:12];
    in4 = d[19:16]; in5 = d[23:20]; in6 = d[27:24]; in7 = d[31:28];
  endtask

  // Pop the oldest expected transfer and compare it with what the DUT offers.
  task automatic sb_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty actual=%0d expected=1", sb.size());
    end else begin
      e = sb.pop_front();
      chk("sb_sel", {29'd0, sel}, {29'd0, e.sel});
      chk("sb_data", {28'd0, data_out}, {28'd0, e.data});
    end
  endtask

  // One full transfer with ready already high: IDLE -> SELECT -> HOLD -> IDLE.
  task automatic xfer(input logic [7:0] r, input logic [31:0] d,
                      input logic [2:0] es, input logic [3:0] ed);
    logic [7:0] oh;
    oh = 8'd1 << es;
    req = r; set_din(d); out_ready = 1'b1;
    sb.push_back('{sel: es, data: ed});
    @(negedge clk);
    chk("x_grant", {24'd0, grant}, {24'd0, oh});
    chk("x_sel", {29'd0, sel}, {29'd0, es});
    chk("x_ack_idle", {24'd0, ack}, 32'd0);
    chk("x_valid_early", {31'd0, out_valid}, 32'd0);
    chk("x_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("x_valid", {31'd0, out_valid}, 32'd1);
    chk("x_data", {28'd0, data_out}, {28'd0, ed});
    sb_pop();
    req = 8'h00;
    @(negedge clk);
    chk("x_ack", {24'd0, ack}, {24'd0, oh});
    chk("x_grant_clr", {24'd0, grant}, 32'd0);
    chk("x_valid_clr", {31'd0, out_valid}, 32'd0);
    chk("x_busy_clr", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, {24'd0, grant}, 32'd0);
    chk({tag, "_ack"}, {24'd0, ack}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_sel"}, {29'd0, sel}, 32'd0);
    chk({tag, "_data"}, {28'd0, data_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // {req, in7..in0, expected sel, expected data}; ptr starts at 0.
    vecs[0] = '{req: 8'h08, din: 32'h0000_A000, sel: 3'd3, dout: 4'hA}; // ptr -> 4
    vecs[1] = '{req: 8'h08, din: 32'h0000_5000, sel: 3'd3, dout: 4'h5}; // wrap scan, ptr -> 4
    vecs[2] = '{req: 8'h21, din: 32'h0060_0009, sel: 3'd5, dout: 4'h6}; // ptr -> 6
    vecs[3] = '{req: 8'h81, din: 32'h7000_0001, sel: 3'd7, dout: 4'h7}; // ptr -> 0
    vecs[4] = '{req: 8'h81, din: 32'hE000_0003, sel: 3'd0, dout: 4'h3}; // ptr -> 1
    vecs[5] = '{req: 8'h21, din: 32'h00B0_0002, sel: 3'd5, dout: 4'hB}; // ptr -> 6
    vecs[6] = '{req: 8'h21, din: 32'h00D0_0004, sel: 3'd0, dout: 4'h4}; // ptr -> 1
    vecs[7] = '{req: 8'h06, din: 32'h0000_0C80, sel: 3'd1, dout: 4'h8}; // ptr -> 2

    // Reset with every requester active.
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1; set_din(32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1; req = 8'h00;
    @(negedge clk);
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);

    // Table-driven transfers.
    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].req, vecs[i].din, vecs[i].sel, vecs[i].dout);
    end

    // Backpressure: requester 2 wins (ptr=2), data changes and req drops during HOLD.
    req = 8'h04; set_din(32'h0000_0C00); out_ready = 1'b0;
    sb.push_back('{sel: 3'd2, data: 4'hC});
    @(negedge clk);
    chk("bp_grant", {24'd0, grant}, 32'h04);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {28'd0, data_out}, 32'hC);
      chk("bp_sel", {29'd0, sel}, 32'd2);
      chk("bp_grant_hold", {24'd0, grant}, 32'h04);
      chk("bp_ack_none", {24'd0, ack}, 32'd0);
      if (c == 0) begin
        set_din(32'h0000_0F00);
        req = 8'h00;
      end
      @(negedge clk);
    end
    sb_pop();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack", {24'd0, ack}, 32'h04);
    chk("bp_grant_clr", {24'd0, grant}, 32'd0);
    chk("bp_valid_clr", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_ack_once", {24'd0, ack}, 32'd0);

    // Reset in HOLD: requester 4 wins (ptr=3), transfer is dropped.
    req = 8'h10; set_din(32'h0009_0000); out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rh_in_hold", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0; req = 8'h00;
    @(negedge clk);
    chk_reset_vals("rh");
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rh_no_ack", {24'd0, ack}, 32'd0);
    // ptr back to 0: lowest set bit wins (a stale ptr of 3 would pick 4).
    xfer(8'h11, 32'h0004_0006, 3'd0, 4'h6);

    // Round robin from ptr 0 with every requester active.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      xfer(8'hFF, 32'h7654_3210, 3'(k % 8), 4'(k % 8));
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
